vga_console: RTL and testbench
==============================

VGA_CONSOLE -- requirements
Module: vga_console

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 25, text rows; COLS*ROWS SHALL NOT exceed 2048.
REQ-003 Parameter FIFO_DEPTH, default 16, input byte buffer entries (power of two).
REQ-004 i_clk  in  1  system clock (16 MHz); sole clock; all logic is rising-edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 in_char  in  8  byte from the bus or UART producer.
REQ-007 in_valid  in  1  in_char is valid this cycle.
REQ-008 in_ready  out  1  space available; a byte is accepted on an edge where in_valid&&in_ready.
REQ-009 write_char  out  8  character code to the VGA character store.
REQ-010 write_char_pos  out  11  linear position, row*COLS+col.
REQ-011 write_char_strobe  out  1  single-cycle write pulse; write_char and write_char_pos are valid while it is high.
REQ-012 cursor_pos  out  11  current cursor, row*COLS+col, for bus readback.
REQ-013 busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-014 Input FIFO: in_ready = !full; a push while full is impossible; simultaneous push and pop is allowed when non-empty, and occupancy is unchanged.
REQ-015 FSM states: IDLE, PUT, CLR_LINE, CLR_ALL.
- IDLE pops one byte per cycle when the FIFO is non-empty.
- The popped byte is decoded and the next state is entered on the same edge.
REQ-016 Printable byte (0x20-0x7E) -> PUT.
- One strobe at the cursor with write_char=byte.
- col+1; at col==COLS-1, col=0 and row advances (REQ-020).
REQ-017 0x0A (LF): col=0, row advances (REQ-020).
REQ-018 0x0D (CR): col=0; no strobe; return to IDLE.
REQ-019 0x08 (BS), col>0: col-1, then one strobe writing 0x20 at the new position.
- col==0: no-op, no strobe.
REQ-020 Row advance: row+1, wrapping ROWS-1 -> 0; then CLR_LINE.
- CLR_LINE issues COLS consecutive strobes of 0x20 at row*COLS .. row*COLS+COLS-1, one per cycle, then returns to IDLE.
- Cursor stays at (row, 0).
REQ-021 0x0C (FF) -> CLR_ALL.
- COLS*ROWS consecutive strobes of 0x20 at positions 0 .. COLS*ROWS-1, then IDLE with cursor 0.
REQ-022 All other bytes are discarded with no strobe and no cursor change.
REQ-023 Latency: byte pushed into an empty FIFO with FSM IDLE at edge N -> popped at edge N+1 -> strobe high in the cycle after edge N+2.
REQ-024 Outputs are registered; strobe is never high for two cycles in PUT.
- CLR states strobe every cycle.
REQ-025 cursor_pos updates on the same edge the FSM leaves PUT, IDLE (CR), or enters CLR_LINE/CLR_ALL.
REQ-026 Position arithmetic is 11-bit unsigned.
- Clear counters SHALL stop exactly at the final position, with no wrap past COLS*ROWS-1.

Reset
REQ-027 i_rst high at an edge:
- FIFO empties; state=IDLE; cursor_pos=0; write_char=0; write_char_pos=0; write_char_strobe=0; busy=0; in_ready=1 on the following cycle.
REQ-028 Reset during CLR_LINE/CLR_ALL abandons the clear immediately; no further strobes.
REQ-029 Screen contents are not cleared by reset; software sends 0x0C.

Structure
REQ-030 Package vga_console_pkg holds: COLS/ROWS defaults, control codes (LF, CR, BS, FF, SPACE), and the state enum.
REQ-031 Sub-module sync_fifo (parameterised width/depth, same clock/reset) implements the input buffer; FSM and cursor logic live in vga_console.

Verification
REQ-032 Reset, push 'A' (0x41) -> one strobe, char 0x41, pos 0, 3 cycles after acceptance; cursor_pos=1.
REQ-033 Cursor at col 79 row 0, push 0x5A -> strobe at pos 79; then 80 strobes of 0x20 at pos 80..159; cursor_pos=80.
REQ-034 Cursor at row 24 col 5, push 0x0A -> 80 space strobes at pos 0..79; cursor_pos=0.
REQ-035 Cursor pos 3, push 0x08 -> one strobe 0x20 at pos 2, cursor_pos=2; at pos 0, push 0x08 -> no strobe, cursor_pos=0.
REQ-036 Push 0x0C then 'B' back-to-back -> 2000 space strobes at pos 0..1999, then 'B' at pos 0; in_ready drops after 16 further pushes during the clear.
REQ-037 Assert i_rst mid-CLR_ALL at pos 500 -> no strobe after the reset edge, cursor_pos=0, FIFO empty, busy=0.

Source files
------------

// File: rtl/vga_console_pkg.sv
// vga_console_pkg: shared constants, control codes, FSM state type and the
// character-write payload used by the text console and its bench.
package vga_console_pkg;

  localparam int unsigned COLS_DEF = 80;
  localparam int unsigned ROWS_DEF = 25;
  localparam int unsigned CHAR_W   = 8;
  localparam int unsigned POS_W    = 11;

  localparam logic [CHAR_W-1:0] CH_LF    = 8'h0A;
  localparam logic [CHAR_W-1:0] CH_CR    = 8'h0D;
  localparam logic [CHAR_W-1:0] CH_BS    = 8'h08;
  localparam logic [CHAR_W-1:0] CH_FF    = 8'h0C;
  localparam logic [CHAR_W-1:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUT,
    ST_CLR_LINE,
    ST_CLR_ALL
  } state_e;

  // One write into the VGA character store.
  typedef struct packed {
    logic [CHAR_W-1:0] ch;
    logic [POS_W-1:0]  pos;
  } char_wr_t;

  // Printable ASCII range 0x20..0x7E.
  function automatic logic is_printable(input logic [CHAR_W-1:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_console_if.sv
// vga_console_if: byte input handshake plus character-store write port,
// cursor readback and busy flag of the text console.
//   master: byte producer / bus side (drives in_char, in_valid)
//   slave : vga_console (drives everything else)
interface vga_console_if;

  logic [7:0]  in_char;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  write_char;
  logic [10:0] write_char_pos;
  logic        write_char_strobe;
  logic [10:0] cursor_pos;
  logic        busy;

  modport master (
    output in_char,
    output in_valid,
    input  in_ready,
    input  write_char,
    input  write_char_pos,
    input  write_char_strobe,
    input  cursor_pos,
    input  busy
  );

  modport slave (
    input  in_char,
    input  in_valid,
    output in_ready,
    output write_char,
    output write_char_pos,
    output write_char_strobe,
    output cursor_pos,
    output busy
  );

endinterface

// File: rtl/vga_console_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO, power-of-two depth.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_push, i_wdata : write request (ignored while full), write data
//   o_ready         : registered not-full
//   i_pop           : read request (ignored while empty)
//   o_rdata         : head entry, valid while !o_empty
//   o_empty         : registered empty
//   o_count         : registered occupancy
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic                       o_ready,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = i_push && ready_q;
  assign pop_ok  = i_pop && !empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    ready_d  = (count_d != CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; contents are only read while non-empty.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_ready = ready_q;
  assign o_empty = empty_q;
  assign o_count = count_q;

endmodule

// File: rtl/vga_console.sv
// vga_console: text console front end. Buffers incoming bytes, interprets
// printable characters and LF/CR/BS/FF, and emits single-cycle writes into a
// COLS x ROWS character store, including line and screen clears.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : in_char/in_valid/in_ready byte input; write_char,
//                  write_char_pos, write_char_strobe store port; cursor_pos
//                  readback; busy
module vga_console
  import vga_console_pkg::*;
#(
  parameter int unsigned COLS       = COLS_DEF,
  parameter int unsigned ROWS       = ROWS_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  vga_console_if.slave bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [POS_W-1:0] COLS_P   = POS_W'(COLS);
  localparam logic [POS_W-1:0] LAST_COL = POS_W'(COLS - 1);
  localparam logic [POS_W-1:0] LAST_ROW = POS_W'(ROWS - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(COLS * ROWS - 1);

  state_e            state_q, state_d;
  logic [POS_W-1:0]  row_q, row_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic [POS_W-1:0]  cursor_q, cursor_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic              bs_q, bs_d;
  logic [POS_W-1:0]  clr_q, clr_d;
  logic [POS_W-1:0]  clr_end_q, clr_end_d;
  char_wr_t          wr_q, wr_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;

  logic              fifo_ready;
  logic              fifo_empty;
  logic [CHAR_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CW-1:0]     occ_next;
  logic [POS_W-1:0]  row_adv;
  logic [POS_W-1:0]  line_base;

  assign fifo_push = bus.in_valid && fifo_ready;

  sync_fifo #(
    .WIDTH (CHAR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (bus.in_valid),
    .i_wdata (bus.in_char),
    .o_ready (fifo_ready),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_rdata),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Decode, cursor movement and store writes.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    char_d    = char_q;
    bs_d      = bs_q;
    clr_d     = clr_q;
    clr_end_d = clr_end_q;
    wr_d      = wr_q;
    strobe_d  = 1'b0;
    fifo_pop  = 1'b0;

    // Next row with wrap, and the first position of that row.
    row_adv   = (row_q == LAST_ROW) ? '0 : row_q + POS_W'(1);
    line_base = row_adv * COLS_P;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_printable(fifo_rdata)) begin
            char_d  = fifo_rdata;
            bs_d    = 1'b0;
            state_d = ST_PUT;
          end else if (fifo_rdata == CH_LF) begin
            col_d     = '0;
            row_d     = row_adv;
            clr_d     = line_base;
            clr_end_d = line_base + LAST_COL;
            state_d   = ST_CLR_LINE;
          end else if (fifo_rdata == CH_CR) begin
            col_d = '0;
          end else if ((fifo_rdata == CH_BS) && (col_q != '0)) begin
            char_d  = CH_SPACE;
            bs_d    = 1'b1;
            state_d = ST_PUT;
          end else if (fifo_rdata == CH_FF) begin
            row_d     = '0;
            col_d     = '0;
            clr_d     = '0;
            clr_end_d = LAST_POS;
            state_d   = ST_CLR_ALL;
          end
        end
      end

      // Backspace moves left first and blanks the new cell; a printable
      // character writes at the cursor and then advances, wrapping the line.
      ST_PUT: begin
        strobe_d = 1'b1;
        wr_d.ch  = char_q;
        state_d  = ST_IDLE;
        if (bs_q) begin
          wr_d.pos = cursor_q - POS_W'(1);
          col_d    = col_q - POS_W'(1);
        end else begin
          wr_d.pos = cursor_q;
          if (col_q == LAST_COL) begin
            col_d     = '0;
            row_d     = row_adv;
            clr_d     = line_base;
            clr_end_d = line_base + LAST_COL;
            state_d   = ST_CLR_LINE;
          end else begin
            col_d = col_q + POS_W'(1);
          end
        end
      end

      // Blank one cell per cycle; the counter halts on the final position.
      ST_CLR_LINE, ST_CLR_ALL: begin
        strobe_d = 1'b1;
        wr_d.ch  = CH_SPACE;
        wr_d.pos = clr_q;
        if (clr_q == clr_end_q) begin
          state_d = ST_IDLE;
        end else begin
          clr_d = clr_q + POS_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cursor_d = row_d * COLS_P + col_d;
    occ_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    busy_d   = (state_d != ST_IDLE) || (occ_next != '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      cursor_q  <= '0;
      char_q    <= '0;
      bs_q      <= 1'b0;
      clr_q     <= '0;
      clr_end_q <= '0;
      wr_q      <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cursor_q  <= cursor_d;
      char_q    <= char_d;
      bs_q      <= bs_d;
      clr_q     <= clr_d;
      clr_end_q <= clr_end_d;
      wr_q      <= wr_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.in_ready          = fifo_ready;
  assign bus.write_char        = wr_q.ch;
  assign bus.write_char_pos    = wr_q.pos;
  assign bus.write_char_strobe = strobe_q;
  assign bus.cursor_pos        = cursor_q;
  assign bus.busy              = busy_q;

endmodule

// File: tb/tb_vga_console.sv
// tb_vga_console: scoreboard bench for vga_console. A reference cursor model
// queues the expected store writes as each byte is accepted; a negedge
// monitor pops and compares them as strobes appear.
module tb_vga_console;
  import vga_console_pkg::*;

  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 25;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_console_if bus();

  vga_console #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_fails   = 0;
  int          cyc       = 0;
  int          acc_cyc   = 0;
  int          n_strobes = 0;
  int unsigned m_row     = 0;
  int unsigned m_col     = 0;
  char_wr_t    exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [7:0] ch, input int unsigned p);
    char_wr_t e;
    e.ch  = ch;
    e.pos = 11'(p);
    exp_q.push_back(e);
  endtask

  task automatic model_adv();
    m_row = (m_row + 1) % ROWS;
    for (int unsigned i = 0; i < COLS; i++) exp_push(CH_SPACE, m_row * COLS + i);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_push(b, m_row * COLS + m_col);
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_adv();
      end else begin
        m_col++;
      end
    end else if (b == CH_LF) begin
      m_col = 0;
      model_adv();
    end else if (b == CH_CR) begin
      m_col = 0;
    end else if (b == CH_BS) begin
      if (m_col > 0) begin
        m_col--;
        exp_push(CH_SPACE, m_row * COLS + m_col);
      end
    end else if (b == CH_FF) begin
      for (int unsigned i = 0; i < COLS * ROWS; i++) exp_push(CH_SPACE, i);
      m_row = 0;
      m_col = 0;
    end
  endtask

  // Store-write monitor.
  always @(negedge clk) begin : mon
    char_wr_t e;
    if (bus.write_char_strobe === 1'b1) begin
      n_strobes++;
      if (exp_q.size() == 0) begin
        check("extra_strobe", 32'(bus.write_char_strobe), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_char", 32'(bus.write_char), 32'(e.ch));
        check("wr_pos", 32'(bus.write_char_pos), 32'(e.pos));
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        bus.in_char  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        acc_cyc      = cyc;
        model_byte(b);
        done         = 1'b1;
      end
    end
    if (!done) check("push_timeout_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int i = 0;
    do begin
      @(negedge clk);
      #1;
      i++;
    end while ((bus.busy !== 1'b0 || exp_q.size() != 0) && i < 6000);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_cursor(input string tag);
    check(tag, 32'(bus.cursor_pos), 32'(m_row * COLS + m_col));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  filled;
    int  s0;
    bit  found;

    bus.in_char  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobe", 32'(bus.write_char_strobe), 32'd0);
    check("rst_char", 32'(bus.write_char), 32'd0);
    check("rst_pos", 32'(bus.write_char_pos), 32'd0);
    check("rst_cursor", 32'(bus.cursor_pos), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // Single printable character and its latency.
    push_byte(8'h41);
    lat   = -1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.write_char_strobe === 1'b1) begin
        lat   = cyc - acc_cyc;
        found = 1'b1;
      end
    end
    check("latency_edges", 32'(lat), 32'd2);
    wait_drain("put_A");
    check_cursor("cursor_A");

    // Fill row 0 to column 79, then wrap with 'Z'.
    for (int i = 0; i < 78; i++) push_byte(8'(8'h21 + (i % 90)));
    wait_drain("fill_row0");
    check_cursor("cursor_col79");
    push_byte(8'h5A);
    wait_drain("wrap_Z");
    check_cursor("cursor_wrap");

    // Walk down to row 24, exercise CR, then LF wrap to row 0.
    for (int i = 0; i < 23; i++) push_byte(CH_LF);
    push_byte(8'h78);
    push_byte(8'h79);
    push_byte(8'h7A);
    push_byte(CH_CR);
    wait_drain("lf_walk");
    check_cursor("cursor_cr_row24");
    for (int i = 0; i < 5; i++) push_byte(8'(8'h61 + i));
    wait_drain("row24_col5");
    check_cursor("cursor_r24c5");
    push_byte(CH_LF);
    wait_drain("lf_wrap");
    check_cursor("cursor_lf_wrap");

    // Backspace mid-line, backspace at column 0, and discarded codes.
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    push_byte(CH_BS);
    wait_drain("bs_mid");
    check_cursor("cursor_bs_mid");
    push_byte(CH_CR);
    s0 = n_strobes;
    push_byte(CH_BS);
    push_byte(8'h01);
    push_byte(8'h7F);
    wait_drain("bs_col0");
    check("bs_col0_strobes", 32'(n_strobes - s0), 32'd0);
    check_cursor("cursor_bs_col0");

    // Full clear with the FIFO filling behind it.
    push_byte(CH_FF);
    push_byte(8'h42);
    filled = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        bus.in_char  = 8'h00;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        model_byte(8'h00);
        filled++;
      end
    end
    check("fill_count", 32'(filled), 32'(DEPTH));
    check("ready_when_full", 32'(bus.in_ready), 32'd0);
    check("busy_during_clr", 32'(bus.busy), 32'd1);
    wait_drain("clr_all");
    check_cursor("cursor_after_ff_B");

    // Reset in the middle of a full clear.
    push_byte(CH_FF);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.write_char_strobe === 1'b1 && bus.write_char_pos == 11'd500) found = 1'b1;
    end
    check("saw_pos500", 32'(found), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(negedge clk);
    check("mid_rst_strobe", 32'(bus.write_char_strobe), 32'd0);
    check("mid_rst_cursor", 32'(bus.cursor_pos), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    s0 = n_strobes;
    repeat (30) @(negedge clk);
    check("post_rst_strobes", 32'(n_strobes - s0), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    push_byte(8'h43);
    wait_drain("after_rst");
    check_cursor("cursor_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
